mult_hilo_unit: RTL and testbench

- Multi-cycle multiply unit with the architectural HI/LO register pair. Sits beside the ALU in the execute stage.
- Decode raises a request when the current function field is MULT or MULTU. This unit runs a radix-2 shift-add multiply, writes the 64-bit product into HI/LO, and stalls the PC until the product is committed.
- MFHI/MFLO read HI/LO through the writeback mux. That mux is outside this block.

---
 rtl/mult_hilo_unit_pkg.sv | 16 +
 rtl/mult_shift_add_core.sv | 59 +++++
 rtl/mult_hilo_unit.sv | 116 +++++++++++
 tb/tb_mult_hilo_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the multiply unit and the ALU control decoder:
// function codes for the HI/LO instructions and the multiply FSM encoding.
package mult_hilo_unit_pkg;

  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mult_state_e;

endpackage

// File: rtl/mult_shift_add_core.sv
// Radix-2 shift-add datapath: accumulator, multiplier shifter and iteration counter.
// load starts a new product; each step consumes one multiplier bit.
module mult_shift_add_core
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b_in,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] addend;

  // Multiplicand is weighted by the current iteration rather than pre-shifted.
  assign addend = {{WIDTH{1'b0}}, mag_a} << cnt_q;

  always_comb begin
    acc_d   = acc_q;
    mag_b_d = mag_b_q;
    cnt_d   = cnt_q;
    if (load) begin
      acc_d   = '0;
      mag_b_d = mag_b_in;
      cnt_d   = '0;
    end else if (step) begin
      if (mag_b_q[0]) begin
        acc_d = acc_q + addend;
      end
      mag_b_d = mag_b_q >> 1;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mag_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mag_b_q <= mag_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_hilo_unit.sv
// MULT/MULTU unit with the architectural HI/LO pair. Runs a fixed-length
// shift-add on operand magnitudes, applies the sign at the end, and stalls the PC.
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mult_req,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int PW = 2 * WIDTH;

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [PW-1:0]      acc;
  logic [PW-1:0]      product;
  logic               last;

  // The done cycle blocks a new accept so a held mult_req cannot re-issue.
  assign accept   = (state_q == ST_IDLE) && mult_req && !done_q;
  assign mag_a_in = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign mag_b_in = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign product  = neg_q ? (~acc + PW'(1)) : acc;

  mult_shift_add_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (state_q == ST_RUN),
    .mag_a    (mag_a_q),
    .mag_b_in (mag_b_in),
    .acc      (acc),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          mag_a_d = mag_a_in;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
      end
      ST_RUN: begin
        if (last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        {hi_d, lo_d} = product;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mag_a_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = (mult_req & ~done_q) | (mf_req & busy_q);

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: a table of signed/unsigned products plus
// hand-written sequences for operand scrambling, mid-op reset and back-to-back issue.
module tb_mult_hilo_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             mult_req;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mf_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  mult_hilo_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .mult_req  (mult_req),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .mf_req    (mf_req),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic sgn, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    is_signed = sgn;
    a         = va;
    b         = vb;
    mult_req  = 1'b1;
    #1;
  endtask

  // Counts negedges until done; stalls counts cycles before done with stall high.
  task automatic wait_done(output int cycles, output int stalls, output logic found);
    cycles = 0;
    stalls = 0;
    found  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        found = 1'b1;
        break;
      end
      if (stall) stalls++;
    end
    if (!found) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got=no done expected=done within 100 cycles");
    end
  endtask

  initial begin
    int          cycles;
    int          stalls;
    int          done_cnt;
    logic        found;
    time         t1;
    time         t2;

    vecs[0]  = '{1'b1, 32'd7,        32'd6,        64'h00000000_0000002A};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[3]  = '{1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFE};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[7]  = '{1'b1, 32'd0,        32'h00012345, 64'h00000000_00000000};
    vecs[8]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
    vecs[9]  = '{1'b0, 32'h12345678, 32'h00000010, 64'h00000001_23456780};
    vecs[10] = '{1'b1, 32'd100,      32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFF9C};

    rst       = 1'b1;
    mult_req  = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    mf_req    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_hilo",  {hi, lo}, 64'h0);
    check_output("reset_busy",  64'(busy), 64'h0);
    check_output("reset_done",  64'(done), 64'h0);
    check_output("reset_stall", 64'(stall), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].sgn, vecs[i].va, vecs[i].vb);
      check_output($sformatf("v%0d_accept_stall", i), 64'(stall), 64'h1);
      wait_done(cycles, stalls, found);
      check_output($sformatf("v%0d_latency", i), 64'(cycles), 64'd34);
      check_output($sformatf("v%0d_stall_cycles", i), 64'(stalls), 64'd33);
      check_output($sformatf("v%0d_done_stall", i), 64'(stall), 64'h0);
      check_output($sformatf("v%0d_product", i), {hi, lo}, vecs[i].exp);
      mult_req = 1'b0;
      @(negedge clk);
      check_output($sformatf("v%0d_done_pulse", i), 64'({done, busy}), 64'h0);
      check_output($sformatf("v%0d_hold", i), {hi, lo}, vecs[i].exp);
    end

    // Operands scrambled and mult_req dropped mid-run; mf_req must stall while busy.
    apply_stimulus(1'b1, 32'd7, 32'd6);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
      a         = $urandom;
      b         = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      if (i == 5) begin
        mult_req = 1'b0;
        mf_req   = 1'b1;
        #1;
        check_output("mf_stall", 64'({stall, busy}), 64'h3);
      end
    end
    check_output("scramble_done_seen", 64'(found), 64'h1);
    check_output("scramble_product", {hi, lo}, 64'h2A);
    mf_req = 1'b0;

    // Reset at iteration 10 discards the product and clears HI/LO.
    apply_stimulus(1'b1, 32'd100, 32'd100);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midreset_busy", 64'({busy, done}), 64'h0);
    check_output("midreset_hilo", {hi, lo}, 64'h0);
    rst      = 1'b0;
    mult_req = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_output("midreset_no_done", 64'(done_cnt), 64'h0);
    apply_stimulus(1'b1, 32'd100, 32'd100);
    wait_done(cycles, stalls, found);
    check_output("fresh_product", {hi, lo}, 64'd10000);
    mult_req = 1'b0;
    @(negedge clk);

    // Back-to-back: second request waits out the done cycle, then issues.
    apply_stimulus(1'b1, 32'd2, 32'd3);
    wait_done(cycles, stalls, found);
    t1 = $time;
    check_output("b2b_first", {hi, lo}, 64'd6);
    a = 32'd4;
    b = 32'd5;
    @(negedge clk);
    check_output("b2b_gap_done", 64'(done), 64'h0);
    check_output("b2b_gap_stall", 64'(stall), 64'h1);
    check_output("b2b_gap_hilo", {hi, lo}, 64'd6);
    repeat (15) @(negedge clk);
    check_output("b2b_mid_hilo", {hi, lo}, 64'd6);
    wait_done(cycles, stalls, found);
    t2 = $time;
    check_output("b2b_spacing", 64'((t2 - t1) / 10), 64'd35);
    check_output("b2b_second", {hi, lo}, 64'd20);
    mult_req = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
